// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sc64 package: shared SDRAM arbiter constants and types.
//   SDRAM_ADDR_W / SDRAM_DATA_W : SDRAM access port geometry
//   sdram_arb_id_e              : requester indices on the SDRAM arbiter
//   e_sdram_arb_state           : arbiter FSM states
//   rr_wrap()                   : single-step modulo used by round-robin scans
// -----------------------------------------------------------------------------
package sc64;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ID_SDRAM_CPU = 2'd0,
        ID_SDRAM_DMA = 2'd1,
        ID_SDRAM_PI  = 2'd2
    } sdram_arb_id_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } e_sdram_arb_state;

    // idx is known to be < 2*n, so one subtraction is a full modulo.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if: requester-side and controller-side buses of the SDRAM
// arbiter, bundled.
//   req_*  : flattened per-requester request bus (requester i at slice i)
//   mem_*  : single request/ack port to the SDRAM controller
// Modports:
//   slave  : arbiter view (serves the requesters, drives the controller)
//   master : environment view (requesters + controller model)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = sc64::SDRAM_ADDR_W,
    parameter int DATA_W  = sc64::SDRAM_DATA_W
);
    localparam int MASK_W = DATA_W / 8;

    logic [NUM_REQ-1:0]        req_request;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*MASK_W-1:0] req_wmask;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         req_rdata;

    logic                      mem_request;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_wdata;
    logic [MASK_W-1:0]         mem_wmask;
    logic                      mem_ack;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_request, req_write, req_address, req_wdata, req_wmask,
        input  mem_ack, mem_rdata,
        output req_ack, req_rdata,
        output mem_request, mem_write, mem_address, mem_wdata, mem_wmask
    );

    modport master (
        output req_request, req_write, req_address, req_wdata, req_wmask,
        output mem_ack, mem_rdata,
        input  req_ack, req_rdata,
        input  mem_request, mem_write, mem_address, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/sdram_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select: combinational round-robin picker.
//   req   in  N   request vector
//   last  in  IW  index granted last time
//   idx   out IW  first requesting index scanning last+1, last+2, ... mod N
//   valid out 1   any request set (idx is meaningful only when set)
// -----------------------------------------------------------------------------
module rr_select
    import sc64::*;
#(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int cand;

    // Scan from the farthest offset down to the nearest so the nearest
    // requesting index after last is what remains.
    always_comb begin
        idx   = last;
        valid = 1'b0;
        cand  = 0;
        for (int k = N; k >= 1; k--) begin
            cand = rr_wrap(int'(last) + k, N);
            if (req[cand[IW-1:0]]) begin
                idx   = cand[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter: shares the SDRAM controller port between NUM_REQ requesters
// (0 = CPU bridge, 1 = DMA, 2 = PI bridge) with round-robin grant and one
// outstanding access at a time.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (also resets the controller)
//   bus      sdram_arbiter_if.slave: req_* requester bus, mem_* controller bus
// Build option:
//   SDRAM_ARB_CPU_PRIORITY_EN  requester 0 wins every arbitration it enters;
//                              the others rotate among themselves.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sc64::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int DATA_W  = SDRAM_DATA_W
) (
    input  logic            clk,
    input  logic            reset_n,
    sdram_arbiter_if.slave  bus
);

    localparam int IW     = $clog2(NUM_REQ);
    localparam int MASK_W = DATA_W / 8;

    e_sdram_arb_state state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic             mem_request_q, mem_request_d;

    logic [NUM_REQ-1:0] rr_req;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;

`ifdef SDRAM_ARB_CPU_PRIORITY_EN
    // CPU is handled ahead of the picker, so only the others rotate.
    assign rr_req = bus.req_request & ~NUM_REQ'(1);
`else
    assign rr_req = bus.req_request;
`endif

    rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
        .req   (rr_req),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_q        <= IW'(NUM_REQ - 1);  // requester 0 wins first
            mem_request_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            mem_request_q <= mem_request_d;
        end
    end

    // Arbitration only happens in IDLE; BUSY just waits for the controller,
    // which gives the one IDLE cycle between consecutive accesses.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        mem_request_d = mem_request_q;
        case (state_q)
            S_IDLE: begin
`ifdef SDRAM_ARB_CPU_PRIORITY_EN
                if (bus.req_request[0]) begin
                    grant_d       = '0;
                    mem_request_d = 1'b1;
                    state_d       = S_BUSY;
                end else
`endif
                if (pick_vld) begin
                    grant_d       = pick_idx;
                    last_d        = pick_idx;
                    mem_request_d = 1'b1;
                    state_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack) begin
                    mem_request_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: mux the granted slice; don't-care while mem_request is low.
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
    logic [NUM_REQ-1:0][MASK_W-1:0] wmask_a;

    assign addr_a  = bus.req_address;
    assign wdata_a = bus.req_wdata;
    assign wmask_a = bus.req_wmask;

    assign bus.mem_request = mem_request_q;
    assign bus.mem_write   = bus.req_write[grant_q];
    assign bus.mem_address = addr_a[grant_q];
    assign bus.mem_wdata   = wdata_a[grant_q];
    assign bus.mem_wmask   = wmask_a[grant_q];

    // A stray mem_ack outside BUSY never reaches a requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
        assign bus.req_ack[gi] = bus.mem_ack && (state_q == S_BUSY) &&
                                 (grant_q == IW'(gi));
    end

    assign bus.req_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter. Tests push the
// accesses they expect, in grant order, to exp_q; the monitor checks each
// access start (mem_* bus) and its completion (req_ack / req_rdata) against
// the queue head. A behavioural controller acks ctrl_lat cycles after
// mem_request is seen.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sc64::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = SDRAM_ADDR_W;
    localparam int DATA_W  = SDRAM_DATA_W;
    localparam int MASK_W  = DATA_W / 8;

    typedef struct {
        int                id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    exp_t e;

    // requester model state
    int                rem    [NUM_REQ] = '{default: 0};
    int                arm    [NUM_REQ] = '{default: 0};
    bit                ack_seen[NUM_REQ] = '{default: 0};
    logic              t_wr   [NUM_REQ] = '{default: 1'b0};
    logic [ADDR_W-1:0] t_addr [NUM_REQ] = '{default: '0};
    logic [DATA_W-1:0] t_wdata[NUM_REQ] = '{default: '0};
    logic [MASK_W-1:0] t_wmask[NUM_REQ] = '{default: '0};

    // controller model state
    int                ctrl_lat = 3;
    int                ctrl_cnt = 0;
    logic [DATA_W-1:0] ctrl_rdata = '0;
    bit                spur_ack = 1'b0;

    // monitor state
    bit req_active = 1'b0;
    bit chk_gap = 1'b0;
    bit gap_armed = 1'b0;
    int ack_cyc = 0;

    // Controller + requesters, all inputs driven #1 after the rising edge.
    initial begin
        bus.req_request = '0;
        bus.req_write   = '0;
        bus.req_address = '0;
        bus.req_wdata   = '0;
        bus.req_wmask   = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (!reset_n) begin
                ctrl_cnt = 0;
            end else if (spur_ack) begin
                bus.mem_ack = 1'b1;
                spur_ack = 1'b0;
            end else if (bus.mem_request) begin
                ctrl_cnt++;
                if (ctrl_cnt >= ctrl_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = ctrl_rdata;
                    ctrl_cnt = 0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_seen[i]) begin
                    ack_seen[i] = 1'b0;
                    if (rem[i] > 0) rem[i]--;
                end
                if (arm[i] > 0 && bus.mem_ack) begin
                    rem[i] = arm[i];
                    arm[i] = 0;
                end
                bus.req_request[i]                   = (rem[i] > 0);
                bus.req_write[i]                     = t_wr[i];
                bus.req_address[i*ADDR_W +: ADDR_W]  = t_addr[i];
                bus.req_wdata[i*DATA_W +: DATA_W]    = t_wdata[i];
                bus.req_wmask[i*MASK_W +: MASK_W]    = t_wmask[i];
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            req_active = 1'b0;
        end else begin
            if (bus.mem_request && !req_active) begin
                req_active = 1'b1;
                if (chk_gap && gap_armed) begin
                    n_chk++;
                    if ((cyc - ack_cyc) !== 2)
                        $display("FAIL idle_gap: ack->request %0d cycles, want 2", cyc - ack_cyc);
                    else n_pass++;
                end
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mem_start: unexpected access addr=%h", bus.mem_address);
                end else begin
                    e = exp_q[0];
                    if (bus.mem_address !== e.addr || bus.mem_write !== e.wr ||
                        (e.wr && (bus.mem_wdata !== e.wdata || bus.mem_wmask !== e.wmask)))
                        $display("FAIL mem_start: got addr=%h wr=%b wd=%h wm=%b, want addr=%h wr=%b wd=%h wm=%b",
                                 bus.mem_address, bus.mem_write, bus.mem_wdata, bus.mem_wmask,
                                 e.addr, e.wr, e.wdata, e.wmask);
                    else n_pass++;
                end
            end else if (bus.mem_ack && req_active) begin
                logic [NUM_REQ-1:0] oh;
                oh = '0;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL req_ack: ack %b with empty scoreboard", bus.req_ack);
                end else begin
                    e = exp_q.pop_front();
                    oh[e.id] = 1'b1;
                    if (bus.req_ack !== oh || (!e.wr && bus.req_rdata !== e.rdata))
                        $display("FAIL req_ack: got ack=%b rdata=%h, want ack=%b rdata=%h",
                                 bus.req_ack, bus.req_rdata, oh, e.rdata);
                    else n_pass++;
                end
                for (int i = 0; i < NUM_REQ; i++)
                    if (bus.req_ack[i]) ack_seen[i] = 1'b1;
                req_active = 1'b0;
                ack_cyc = cyc;
                gap_armed = chk_gap;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.mem_request !== 1'b0) $display("FAIL reset_mem_request: got %b want 0", bus.mem_request);
        else n_pass++;
        n_chk++;
        if (bus.req_ack !== '0) $display("FAIL reset_req_ack: got %b want 000", bus.req_ack);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.mem_request !== 1'b0) $display("FAIL idle_no_req: got %b want 0", bus.mem_request);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        exp_t x;
        @(negedge clk);
        ctrl_lat = 2;
        ctrl_rdata = 16'h5A00;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_wr[i] = 1'b0;
            t_addr[i] = ADDR_W'(32'h100 * (i + 1));
        end
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_REQ; i++) begin
                x = '{id: i, wr: 1'b0, addr: t_addr[i], wdata: '0, wmask: '0, rdata: 16'h5A00};
                exp_q.push_back(x);
            end
        gap_armed = 1'b0;
        chk_gap = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rem[i] = 3;
        for (int k = 0; k < 300 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        chk_gap = 1'b0;
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL rr_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

`ifdef SDRAM_ARB_CPU_PRIORITY_EN
    task automatic test_cpu_priority();
        exp_t x;
        int order[7] = '{0, 0, 0, 1, 2, 1, 2};
        @(negedge clk);
        ctrl_lat = 2;
        ctrl_rdata = 16'h0C0C;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_wr[i] = 1'b0;
            t_addr[i] = ADDR_W'(32'h400 + 32'h10 * i);
        end
        foreach (order[j]) begin
            x = '{id: order[j], wr: 1'b0, addr: t_addr[order[j]], wdata: '0, wmask: '0, rdata: 16'h0C0C};
            exp_q.push_back(x);
        end
        rem[0] = 3;
        rem[1] = 2;
        rem[2] = 2;
        for (int k = 0; k < 300 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL prio_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_single_read();
        exp_t x;
        @(negedge clk);
        ctrl_lat = 3;
        ctrl_rdata = 16'hBEEF;
        t_wr[1] = 1'b0;
        t_addr[1] = 26'h0001234;
        x = '{id: 1, wr: 1'b0, addr: 26'h0001234, wdata: '0, wmask: '0, rdata: 16'hBEEF};
        exp_q.push_back(x);
        rem[1] = 1;
        @(negedge clk);  // request is up, grant not yet registered
        n_chk++;
        if (bus.mem_request !== 1'b0) $display("FAIL read_grant_early: got %b want 0", bus.mem_request);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.mem_request !== 1'b1) $display("FAIL read_grant_lat: got %b want 1", bus.mem_request);
        else n_pass++;
        for (int k = 0; k < 50 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL read_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        exp_t x;
        @(negedge clk);
        ctrl_lat = 2;
        t_wr[2] = 1'b1;
        t_addr[2] = 26'h0000ABC;
        t_wdata[2] = 16'hA55A;
        t_wmask[2] = 2'b01;
        x = '{id: 2, wr: 1'b1, addr: 26'h0000ABC, wdata: 16'hA55A, wmask: 2'b01, rdata: '0};
        exp_q.push_back(x);
        rem[2] = 1;
        for (int k = 0; k < 50 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL write_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.req_ack !== '0) $display("FAIL write_ack_width: got %b want 000", bus.req_ack);
        else n_pass++;
        t_wr[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_collision();
        exp_t x;
        int k;
        @(negedge clk);
        ctrl_lat = 3;
        ctrl_rdata = 16'h7788;
        t_wr[0] = 1'b0;
        t_wr[1] = 1'b0;
        t_addr[1] = 26'h0000040;
        t_addr[0] = 26'h0000080;
        x = '{id: 1, wr: 1'b0, addr: 26'h0000040, wdata: '0, wmask: '0, rdata: 16'h7788};
        exp_q.push_back(x);
        x = '{id: 0, wr: 1'b0, addr: 26'h0000080, wdata: '0, wmask: '0, rdata: 16'h7788};
        exp_q.push_back(x);
        rem[1] = 1;
        arm[0] = 1;  // requester 0 rises together with requester 1's mem_ack
        for (k = 0; k < 50 && !bus.mem_ack; k++) @(negedge clk);
        n_chk++;
        if (!bus.mem_ack) $display("FAIL coll_ack_wait: mem_ack=%b want 1", bus.mem_ack);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.mem_request !== 1'b0) $display("FAIL coll_idle: got %b want 0", bus.mem_request);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.mem_request !== 1'b1) $display("FAIL coll_grant: got %b want 1", bus.mem_request);
        else n_pass++;
        for (k = 0; k < 50 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL coll_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
        // stray controller ack while idle
        spur_ack = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.mem_ack !== 1'b1 || bus.req_ack !== '0 || bus.mem_request !== 1'b0)
            $display("FAIL idle_stray_ack: mem_ack=%b req_ack=%b mem_req=%b want 1/000/0",
                     bus.mem_ack, bus.req_ack, bus.mem_request);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t x;
        int k;
        @(negedge clk);
        ctrl_lat = 8;
        ctrl_rdata = 16'h1357;
        t_wr[0] = 1'b0;
        t_wr[2] = 1'b0;
        t_addr[2] = 26'h0000200;
        t_addr[0] = 26'h0000300;
        x = '{id: 2, wr: 1'b0, addr: 26'h0000200, wdata: '0, wmask: '0, rdata: 16'h1357};
        exp_q.push_back(x);
        rem[2] = 1;
        for (k = 0; k < 20 && !bus.mem_request; k++) @(negedge clk);
        rem[0] = 1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        n_chk++;
        if (bus.mem_request !== 1'b0) $display("FAIL rst_mid_mem_request: got %b want 0", bus.mem_request);
        else n_pass++;
        n_chk++;
        if (bus.req_ack !== '0) $display("FAIL rst_mid_req_ack: got %b want 000", bus.req_ack);
        else n_pass++;
        x = '{id: 0, wr: 1'b0, addr: 26'h0000300, wdata: '0, wmask: '0, rdata: 16'h1357};
        exp_q.push_back(x);
        x = '{id: 2, wr: 1'b0, addr: 26'h0000200, wdata: '0, wmask: '0, rdata: 16'h1357};
        exp_q.push_back(x);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (k = 0; k < 100 && (exp_q.size() > 0 || req_active); k++) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0 || req_active) $display("FAIL rst_mid_drain: %0d pending, want 0", exp_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifdef SDRAM_ARB_CPU_PRIORITY_EN
        test_cpu_priority();
`else
        test_round_robin();
`endif
        test_single_read();
        test_write();
        test_ack_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
